// File: rtl/lives_hit_manager.sv
// Player-tank lives tracker: hit counting, frame-based invulnerability with blink, respawn strobe, game over.
// Optional build macro EXTRA_LIFE_EN enables bonusEvent pickups that give back one life.
module lives_hit_manager #(
    parameter int MAX_LIVES     = 3,
    parameter int INVULN_FRAMES = 120,
    parameter int BLINK_FRAMES  = 8
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       startOfFrame,
    input  logic       hitEvent,
    input  logic       bonusEvent,
    input  logic       restart,
    output logic [1:0] death,
    output logic       gameOver,
    output logic       invulnerable,
    output logic       tankVisible,
    output logic       respawnPulse
);

    typedef enum logic [1:0] {ALIVE, INVULN, GAME_OVER} state_t;

    localparam logic [1:0] MAX_L  = 2'(MAX_LIVES);
    localparam logic [7:0] INV_F  = 8'(INVULN_FRAMES);
    localparam logic [7:0] BLK_F  = 8'(BLINK_FRAMES);

    state_t     state_q, state_d;
    logic [1:0] death_q, death_d;
    logic [7:0] frame_cnt_q, frame_cnt_d;
    logic       hit_d_q;
    logic       hit_rise;
    logic       bonus_rise;
    logic       respawn_q, respawn_d;
    logic       game_over_q, game_over_d;
    logic       invuln_q, invuln_d;
    logic       visible_q, visible_d;
    logic [7:0] elapsed;
    logic [7:0] blink_idx;

    assign hit_rise = hitEvent & ~hit_d_q;

`ifdef EXTRA_LIFE_EN
    logic bonus_d_q;
    assign bonus_rise = bonusEvent & ~bonus_d_q;
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) bonus_d_q <= 1'b0;
        else         bonus_d_q <= bonusEvent;
    end
`else
    logic unused_bonus;
    assign unused_bonus = bonusEvent;
    assign bonus_rise   = 1'b0;
`endif

    // State register together with the counters it owns
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q     <= ALIVE;
            death_q     <= 2'd0;
            frame_cnt_q <= 8'd0;
            hit_d_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            death_q     <= death_d;
            frame_cnt_q <= frame_cnt_d;
            hit_d_q     <= hitEvent;
        end
    end

    always_comb begin
        state_d     = state_q;
        death_d     = death_q;
        frame_cnt_d = frame_cnt_q;
        respawn_d   = 1'b0;
        if (restart) begin
            state_d     = ALIVE;
            death_d     = 2'd0;
            frame_cnt_d = 8'd0;
        end else begin
            case (state_q)
                ALIVE: begin
                    if (hit_rise) begin
                        if (death_q + 2'd1 == MAX_L) begin
                            state_d = GAME_OVER;
                            death_d = MAX_L;
                        end else begin
                            state_d     = INVULN;
                            death_d     = death_q + 2'd1;
                            frame_cnt_d = INV_F;
                            respawn_d   = 1'b1;
                        end
                    end else if (bonus_rise && death_q != 2'd0) begin
                        death_d = death_q - 2'd1;
                    end
                end
                INVULN: begin
                    if (startOfFrame) begin
                        if (frame_cnt_q <= 8'd1) begin
                            frame_cnt_d = 8'd0;
                            state_d     = ALIVE;
                        end else begin
                            frame_cnt_d = frame_cnt_q - 8'd1;
                        end
                    end
                    if (bonus_rise && death_q != 2'd0) death_d = death_q - 2'd1;
                end
                GAME_OVER: death_d = MAX_L;
                default: begin
                    state_d = ALIVE;
                    death_d = 2'd0;
                end
            endcase
        end
    end

    // Outputs follow the next state so they land on the same edge as the state change
    always_comb begin
        elapsed     = INV_F - frame_cnt_d;
        blink_idx   = elapsed / BLK_F;
        game_over_d = 1'b0;
        invuln_d    = 1'b0;
        visible_d   = 1'b1;
        case (state_d)
            INVULN: begin
                invuln_d  = 1'b1;
                visible_d = ~blink_idx[0];
            end
            GAME_OVER: begin
                game_over_d = 1'b1;
                visible_d   = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            respawn_q   <= 1'b0;
            game_over_q <= 1'b0;
            invuln_q    <= 1'b0;
            visible_q   <= 1'b1;
        end else begin
            respawn_q   <= respawn_d;
            game_over_q <= game_over_d;
            invuln_q    <= invuln_d;
            visible_q   <= visible_d;
        end
    end

    assign death        = death_q;
    assign gameOver     = game_over_q;
    assign invulnerable = invuln_q;
    assign tankVisible  = visible_q;
    assign respawnPulse = respawn_q;

endmodule
